// File: rtl/data_mem_bytelane_pkg.sv
// Shared definitions for the RV32I data memory: funct3 codes, FSM states and the alignment rule.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Access size comes from funct3[1:0]; the unsigned variants share the rule of their signed twin.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_bytelane_if.sv
// Request/response bus between the core memory stage and the data memory.
interface data_mem_bytelane_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;

  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata,
    input  ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata,
    output ready, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/data_mem_bytelane_lane_align.sv
// Combinational byte-lane steering: store enables/replicated data and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rd_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be      = '0;
    o_wr_word = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_be      = 4'b0001 << i_lane;
        o_wr_word = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be      = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wr_word = {2{i_wdata[15:0]}};
      end
      2'b10:   o_be = '1;
      default: o_be = '0;
    endcase
  end

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_rd_word[7:0];
      2'd1:    w_byte = i_rd_word[15:8];
      2'd2:    w_byte = i_rd_word[23:16];
      default: w_byte = i_rd_word[31:24];
    endcase
    w_half = i_lane[1] ? i_rd_word[31:16] : i_rd_word[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_ld_data = i_rd_word;
      F3_BU:   o_ld_data = {24'h0, w_byte};
      F3_HU:   o_ld_data = {16'h0, w_half};
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// Word-organised RV32I data memory with byte/half/word access, fault flags and a post-reset clear sequencer.
module data_mem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_bytelane_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t          r_state, w_state_next;
  logic [AW-1:0]   r_clear_idx;
  logic            r_ready;
  logic            r_rsp_valid;
  logic            r_rsp_fault;
  logic [31:0]     r_rsp_data;

  logic            w_clr_we;
  logic            w_accept;
  logic            w_in_range;
  logic            w_illegal;
  logic            w_fault;
  logic            w_store;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_lane;
  logic [3:0]      w_be_raw;
  logic [3:0]      w_be;
  logic [31:0]     w_wr_word;
  logic [31:0]     w_rd_word;
  logic [31:0]     w_ld_data;

  assign w_idx      = bus.req_addr[AW+1:2];
  assign w_lane     = bus.req_addr[1:0];
  assign w_accept   = bus.req_valid && r_ready;
  assign w_in_range = (bus.req_addr[31:AW+2] == '0);
  assign w_illegal  = bus.req_write ? (bus.req_funct3 > F3_W)
                                    : (bus.req_funct3 == 3'd3 || bus.req_funct3[2:1] == 2'b11);
  assign w_fault    = !w_in_range || w_illegal || is_misaligned(bus.req_funct3, w_lane);
  assign w_store    = w_accept && bus.req_write && !w_fault;
  assign w_be       = w_store ? w_be_raw : '0;

  dmem_lane_align u_align (
    .i_funct3  (bus.req_funct3),
    .i_lane    (w_lane),
    .i_wdata   (bus.req_wdata),
    .i_rd_word (w_rd_word),
    .o_be      (w_be_raw),
    .o_wr_word (w_wr_word),
    .o_ld_data (w_ld_data)
  );

  always_comb begin
    w_state_next = r_state;
    w_clr_we     = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clear_idx == '1) w_state_next = READY;
      end
      READY: w_state_next = READY;
      default: w_state_next = r_state;
    endcase
  end

  // ready tracks the state register exactly, so it rises on the edge that retires the last clear write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= CLEAR_ON_RESET ? CLEAR : READY;
      r_clear_idx <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ready     <= (w_state_next == READY);
      if (w_clr_we) r_clear_idx <= r_clear_idx + AW'(1);
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_fault <= w_fault;
        r_rsp_data  <= (bus.req_write || w_fault) ? '0 : w_ld_data;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (w_clr_we)    r_mem[r_clear_idx] <= '0;
      else if (w_be[g]) r_mem[w_idx]      <= w_wr_word[8*g +: 8];
    end

    assign w_rd_word[8*g +: 8] = r_mem[w_idx];
  end

  assign bus.ready     = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Scoreboard bench for data_mem_bytelane with a 16-word memory and directed load/store vectors.
module tb_data_mem_bytelane;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  data_mem_bytelane_if bus ();

  data_mem_bytelane #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_d, input logic exp_f, input bit expect_rsp);
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    if (expect_rsp) begin
      e.name  = nm;
      e.data  = exp_d;
      e.fault = exp_f;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asserts reset, checks the cleared outputs, releases it and measures the clear duration.
  // With poke set, a store is held on the bus throughout the clear; it must be ignored.
  task automatic reset_and_clear(input string nm, input bit poke);
    int cyc;
    reset = 1'b1;
    #1;
    check({nm, ".ready_in_reset"},     {31'b0, bus.ready},     32'd0);
    check({nm, ".rsp_valid_in_reset"}, {31'b0, bus.rsp_valid}, 32'd0);
    check({nm, ".rsp_data_in_reset"},  bus.rsp_data,           32'd0);
    check({nm, ".rsp_fault_in_reset"}, {31'b0, bus.rsp_fault}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    if (poke) begin
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = F3_W;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'hFFFF_FFFF;
    end
    cyc = 0;
    while (cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ready === 1'b1) break;
    end
    bus.req_valid = 1'b0;
    check({nm, ".clear_cycles"}, cyc, DEPTH);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.rsp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%08h, want rsp_valid=0", bus.rsp_data);
        end else begin
          e = sb_q.pop_front();
          check({e.name, ".data"},  bus.rsp_data,           e.data);
          check({e.name, ".fault"}, {31'b0, bus.rsp_fault}, {31'b0, e.fault});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    idle(1);

    reset_and_clear("init", 1'b1);
    for (int unsigned i = 0; i < DEPTH; i++)
      issue("clr_lw", 1'b0, F3_W, 32'(i * 4), 32'h0, 32'h0, 1'b0, 1'b1);

    issue("sw_8",   1'b1, F3_W,  32'h8, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1);
    issue("lb_8",   1'b0, F3_B,  32'h8, 32'h0,         32'hFFFF_FFEF, 1'b0, 1'b1);
    issue("lbu_b",  1'b0, F3_BU, 32'hB, 32'h0,         32'h0000_00DE, 1'b0, 1'b1);
    issue("lh_a",   1'b0, F3_H,  32'hA, 32'h0,         32'hFFFF_DEAD, 1'b0, 1'b1);
    issue("lhu_8",  1'b0, F3_HU, 32'h8, 32'h0,         32'h0000_BEEF, 1'b0, 1'b1);
    issue("lw_8",   1'b0, F3_W,  32'h8, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1);
    idle(1);
    check("hold.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("hold.rsp_data",  bus.rsp_data,           32'hDEAD_BEEF);

    issue("sw_4",   1'b1, F3_W,  32'h4, 32'h1122_3344, 32'h0,         1'b0, 1'b1);
    issue("sb_5",   1'b1, F3_B,  32'h5, 32'h0000_00AA, 32'h0,         1'b0, 1'b1);
    issue("lw_4a",  1'b0, F3_W,  32'h4, 32'h0,         32'h1122_AA44, 1'b0, 1'b1);
    issue("sh_6",   1'b1, F3_H,  32'h6, 32'h0000_BEEF, 32'h0,         1'b0, 1'b1);
    issue("lw_4b",  1'b0, F3_W,  32'h4, 32'h0,         32'hBEEF_AA44, 1'b0, 1'b1);
    idle(1);

    issue("f_lw_2",    1'b0, F3_W,  32'h2,         32'h0,         32'h0, 1'b1, 1'b1);
    issue("f_sh_1",    1'b1, F3_H,  32'h1,         32'h0000_FFFF, 32'h0, 1'b1, 1'b1);
    issue("f_lw_top",  1'b0, F3_W,  32'h40,        32'h0,         32'h0, 1'b1, 1'b1);
    issue("f_sw_top",  1'b1, F3_W,  32'h40,        32'h1234_5678, 32'h0, 1'b1, 1'b1);
    issue("f_ld_f3_3", 1'b0, 3'd3,  32'h0,         32'h0,         32'h0, 1'b1, 1'b1);
    issue("f_ld_f3_6", 1'b0, 3'd6,  32'h8,         32'h0,         32'h0, 1'b1, 1'b1);
    issue("f_st_f3_3", 1'b1, 3'd3,  32'h0,         32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    issue("f_lhu_9",   1'b0, F3_HU, 32'h9,         32'h0,         32'h0, 1'b1, 1'b1);
    issue("f_lw_high", 1'b0, F3_W,  32'h8000_0000, 32'h0,         32'h0, 1'b1, 1'b1);
    issue("unch_w0",   1'b0, F3_W,  32'h0,         32'h0,         32'h0,         1'b0, 1'b1);
    issue("unch_w1",   1'b0, F3_W,  32'h4,         32'h0,         32'hBEEF_AA44, 1'b0, 1'b1);
    issue("unch_w2",   1'b0, F3_W,  32'h8,         32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1);

    issue("b2b_sw", 1'b1, F3_W, 32'h0, 32'h0000_0005, 32'h0,         1'b0, 1'b1);
    issue("b2b_lw", 1'b0, F3_W, 32'h0, 32'h0,         32'h0000_0005, 1'b0, 1'b1);
    idle(2);

    reset = 1'b1;
    #1;
    reset = 1'b0;
    idle(5);
    reset_and_clear("midclear", 1'b0);

    issue("pre_rst_sw", 1'b1, F3_W, 32'h8, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
    idle(1);
    issue("dropped_lw", 1'b0, F3_W, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);
    check("inflight.rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    reset_and_clear("midreq", 1'b0);
    issue("post_clr_w2", 1'b0, F3_W, 32'h8, 32'h0, 32'h0, 1'b0, 1'b1);
    issue("post_clr_w0", 1'b0, F3_W, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(3);

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
